ins_fetch_unit: RTL
===================

# ins_fetch_unit

Instruction-byte fetch unit for the 8051 core. It owns the program counter, issues reads to the synchronous program ROM and buffers returned bytes in a small prefetch queue. It presents them one at a time to the instruction decoder over a valid/ready handshake. Opcode and operand bytes are treated identically: the decoder pops as many bytes as each instruction needs. A PC load from the execute stage flushes the queue and redirects fetch.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, first byte address fetched after reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rom_rd`  out  1  ROM read strobe; one byte requested per cycle it is high.
- `rom_addr`  out  16  ROM byte address; meaningful only while `rom_rd`=1.
- `rom_data`  in  8  ROM read data; valid the cycle after the matching `rom_rd`.
- `instruction`  out  8  byte at the head of the queue.
- `ins_pc`  out  16  ROM address of `instruction`.
- `ins_valid`  out  1  head entry present.
- `ins_ready`  in  1  decoder accepts head byte; pop = `ins_valid & ins_ready`.
- `pc_load`  in  1  one-cycle redirect request.
- `pc_load_value`  in  16  new fetch address.

## Operation
- State: `pc` (next address to request), a queue of DEPTH entries of {byte, address}, `count`, `inflight` (a read was issued last cycle), `drop` (discard the in-flight return), and a 2-state FSM.
- FSM states:
  - S_BOOT is entered on reset. It does not issue. It moves unconditionally to S_RUN on the next edge.
  - S_RUN is the normal fetch state. No other states exist.
- Issue rule (S_RUN only): `rom_rd` = !`pc_load` & (`count` + `inflight` − pop < DEPTH). `rom_addr` = `pc`. On issue, `pc` increments by 1, wrapping 16'hFFFF to 16'h0000.
- Return: if `inflight` & !`drop` & !`pc_load`, then {`rom_data`, address} is written at the tail. The address is registered at issue.
- Queue: `instruction`/`ins_pc` show the head entry. A simultaneous push and pop keeps `count` unchanged. Overflow is impossible by construction of the issue rule.
- `pc_load` (priority over everything):
  - At the edge, `pc` ← `pc_load_value`, `count` ← 0, `inflight` ← 0.
  - `drop` ← `inflight`, so any read issued in the `pc_load` cycle's predecessor is discarded on return.
  - A pop in the same cycle is ignored.
- `ins_ready` while `ins_valid`=0 has no effect.

## Timing
- Reset values: `rom_rd`=0, `rom_addr`=`RESET_PC`, `ins_valid`=0, `instruction`=8'h00, `ins_pc`=`RESET_PC`. Internally, `pc`=`RESET_PC`, `count`=0, `inflight`=0, `drop`=0, FSM=S_BOOT.
- Cycle 0 is the first cycle after `rst` deasserts, spent in S_BOOT. The first `rom_rd` occurs in cycle 1. Its data arrives in cycle 2 and `ins_valid` rises in cycle 3.
- Redirect: for `pc_load` in cycle N, `ins_valid`=0 in N+1. The first read at `pc_load_value` is issued in N+1 and its byte is valid in N+3.
- Steady state with `ins_ready` held high: one byte per cycle, `ins_pc` incrementing by 1.
- Back-pressure: with `ins_ready`=0, fetch stops once `count`+`inflight` = DEPTH. The head is held stable, and issuing resumes in the same cycle as the first pop.
- `rst` mid-operation forces all reset values immediately (asynchronously). An in-flight ROM return after reset release is never written.

## Configuration
- `INS_PREFETCH_EN` defined:
  - DEPTH=2, and the issue rule includes the pop credit as written above.
  - Throughput is 1 byte/cycle.
- `INS_PREFETCH_EN` undefined:
  - DEPTH=1, and the issue condition becomes `count`==0 & !`inflight` (no pop credit).
  - A new byte is available every 3 cycles under continuous `ins_ready`.
  - All other behaviour and reset values are identical.

## Test plan
- Reset release, RESET_PC=16'h0000, ROM[i]=i, `ins_ready`=1:
  - `rom_rd` first rises in cycle 1.
  - `ins_valid` rises in cycle 3 with `instruction`=8'h00 and `ins_pc`=16'h0000.
  - Bytes 8'h01, 8'h02, … then follow every cycle (every 3 cycles without `INS_PREFETCH_EN`).
- Back-pressure: hold `ins_ready`=0 for 10 cycles after the first valid:
  - `rom_rd` goes low after 2 issues (1 without the macro).
  - `instruction` stays 8'h00.
  - On release, bytes 00,01,02,… arrive with no gap or duplicate.
- Redirect: assert `pc_load` with `pc_load_value`=16'h0100 while a read is in flight:
  - `ins_valid`=0 the next cycle.
  - The stale byte is never presented.
  - The first valid byte has `ins_pc`=16'h0100, 2 cycles after `ins_valid` drops.
- Wrap: `pc_load_value`=16'hFFFE → consecutive `ins_pc` values are FFFE, FFFF, 0000, 0001.
- Simultaneous `pc_load` and pop: the pop is ignored and the next presented byte comes from `pc_load_value`.
- Asynchronous `rst` pulse mid-stream:
  - `ins_valid` and `rom_rd` drop within the same cycle.
  - Fetch restarts at RESET_PC after one S_BOOT cycle.

Source files
------------

// File: rtl/ins_fetch_unit.sv
// ---------------------------------------------------------------------------
// ins_fetch_unit
//
// Instruction-byte fetch unit for the 8051 core. Owns the program counter,
// issues byte reads to the synchronous program ROM and buffers the returned
// bytes in a small prefetch queue. The decoder pops bytes one at a time over
// a valid/ready handshake; opcode and operand bytes are not distinguished.
// A PC load from the execute stage flushes the queue and redirects fetch.
//
// Configuration macro:
//   INS_PREFETCH_EN  defined   -> two-entry queue, a pop in the same cycle
//                                 frees a slot for a new read (1 byte/cycle)
//                    undefined -> one-entry queue, a read is issued only when
//                                 the queue is empty and nothing is in flight
//
// Parameters:
//   RESET_PC        first byte address fetched after reset
//
// Ports:
//   clk             core clock, rising edge
//   rst             asynchronous active-high reset
//   rom_rd          ROM read strobe, one byte per cycle it is high
//   rom_addr        ROM byte address (meaningful while rom_rd=1)
//   rom_data        ROM read data, valid the cycle after rom_rd
//   instruction     byte at the head of the queue
//   ins_pc          ROM address of instruction
//   ins_valid       head entry present
//   ins_ready       decoder accepts the head byte
//   pc_load         one-cycle redirect request
//   pc_load_value   new fetch address
// ---------------------------------------------------------------------------
module ins_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_rd,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  instruction,
  output logic [15:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value
);

`ifdef INS_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] pc;
  logic [15:0] issue_addr;
  logic [7:0]  q_byte [DEPTH];
  logic [15:0] q_addr [DEPTH];
  logic [1:0]  count;
  logic        inflight;
  logic        drop;

  logic        pop;
  logic        push;
  logic        issue;
  logic        room;
  logic [1:0]  wr_idx;

  // A pop in a redirect cycle is ignored: the queue is being flushed anyway,
  // so the decoder must not see its byte as consumed.
  assign pop  = ins_valid & ins_ready & ~pc_load;

  // The ROM answers one cycle after the strobe. A redirect in the return
  // cycle, or a return belonging to a read issued before a redirect, is
  // discarded instead of written.
  assign push = inflight & ~drop & ~pc_load;

  // After a pop the surviving entries move down one slot, so a new byte
  // lands right behind whatever is left.
  assign wr_idx = count - {1'b0, pop};

  assign ins_valid   = (count != 2'd0);
  assign instruction = q_byte[0];
  assign ins_pc      = q_addr[0];
  assign rom_addr    = pc;
  assign rom_rd      = issue;

`ifdef INS_PREFETCH_EN
  // Space check counts the byte still on its way back from the ROM and
  // credits a pop happening this cycle, which is what lets the queue stream
  // one byte per cycle while never overflowing.
  logic [2:0] occupancy;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign room      = (occupancy < 3'(DEPTH));
`else
  // Single-entry mode: strictly one outstanding byte at a time.
  assign room      = (count == 2'd0) & ~inflight;
`endif

  // FSM state register. S_BOOT gives one quiet cycle after reset release so
  // the ROM is never strobed in the same cycle reset drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and read-issue decode. Reads are only issued in S_RUN and
  // never in a redirect cycle, since pc still holds the old stream address.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      S_BOOT: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        issue = ~pc_load & room;
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  // Program counter, in-flight tracking and queue occupancy. A redirect
  // wins over everything: it empties the queue, cancels tracking of the
  // current read and marks any read still outstanding for discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      issue_addr <= RESET_PC;
      count      <= 2'd0;
      inflight   <= 1'b0;
      drop       <= 1'b0;
    end else if (pc_load) begin
      pc       <= pc_load_value;
      count    <= 2'd0;
      inflight <= 1'b0;
      drop     <= inflight;
    end else begin
      if (issue) begin
        pc         <= pc + 16'd1;
        issue_addr <= pc;
      end
      inflight <= issue;
      drop     <= 1'b0;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage, head always at index 0. On a pop everything shifts down;
  // a returning byte is then written at the first free slot, overriding the
  // shift for that slot when both happen together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_byte[i] <= 8'h00;
        q_addr[i] <= RESET_PC;
      end
    end else if (!pc_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && (i < DEPTH - 1)) begin
          q_byte[i] <= q_byte[(i + 1) % DEPTH];
          q_addr[i] <= q_addr[(i + 1) % DEPTH];
        end
        if (push && (int'(wr_idx) == i)) begin
          q_byte[i] <= rom_data;
          q_addr[i] <= issue_addr;
        end
      end
    end
  end

endmodule
